fare_total_seq: RTL

Sequential, parametrised successor to the combinational two-input fare adder. It sums CHANNELS BCD fare operands of DIGITS digits each, one digit per clock, LSD first, and saturates to a cap with a max flag. It sits between the per-category fare calculators (distance, waiting, surcharges) and the display driver. A start/busy/done handshake replaces the always-live combinational output.

---
 rtl/fare_pkg.sv | 22 ++
 rtl/fare_total_seq_bcd_digit_add.sv | 21 ++
 rtl/fare_total_seq.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/fare_pkg.sv
// Shared constants, FSM state type and helpers for the sequential BCD fare totaliser.
package fare_pkg;

    localparam int                     BCD_DIGIT_W = 4;
    localparam logic [BCD_DIGIT_W-1:0] BCD_NINE    = 4'd9;
    localparam int                     MAX_DIGITS  = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ADD    = 2'd1,
        ST_FINISH = 2'd2
    } fsm_state_e;

    // Upper digits beyond 'digits' stay zero so callers can size-cast the result.
    function automatic logic [MAX_DIGITS*BCD_DIGIT_W-1:0] all_nines(input int digits);
        all_nines = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < digits) all_nines[i*BCD_DIGIT_W +: BCD_DIGIT_W] = BCD_NINE;
        end
    endfunction

endpackage

// File: rtl/fare_total_seq_bcd_digit_add.sv
// One BCD digit adder: a + b + carry_in, decimal-corrected by +6 when the raw sum exceeds nine.
module bcd_digit_add
    import fare_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] a_i,
    input  logic [BCD_DIGIT_W-1:0] b_i,
    input  logic                   cin_i,
    output logic [BCD_DIGIT_W-1:0] sum_o,
    output logic                   cout_o
);

    logic [BCD_DIGIT_W:0] raw;

    always_comb begin
        raw    = {1'b0, a_i} + {1'b0, b_i} + {{BCD_DIGIT_W{1'b0}}, cin_i};
        cout_o = (raw > {1'b0, BCD_NINE});
        // Wrapping the low nibble by +6 gives the corrected digit for raw 10..19.
        sum_o  = cout_o ? (raw[BCD_DIGIT_W-1:0] + 4'd6) : raw[BCD_DIGIT_W-1:0];
    end

endmodule

// File: rtl/fare_total_seq.sv
// Sums CHANNELS BCD fares one digit per clock (LSD first) and saturates the result to CAP_BCD.
module fare_total_seq
    import fare_pkg::*;
#(
    parameter int                              DIGITS   = 4,
    parameter int                              CHANNELS = 2,
    parameter logic [DIGITS*BCD_DIGIT_W-1:0]   CAP_BCD  = (DIGITS*BCD_DIGIT_W)'(all_nines(DIGITS))
) (
    input  logic                                   sys_clk,
    input  logic                                   sys_rst_n,
    input  logic                                   start,
    input  logic [CHANNELS*DIGITS*BCD_DIGIT_W-1:0] fare_in_bcd,
    output logic                                   busy,
    output logic                                   done,
    output logic [DIGITS*BCD_DIGIT_W-1:0]          fare_total_bcd,
    output logic                                   max,
    output logic                                   bcd_err
);

    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int DIG_W = (DIGITS > 1)   ? $clog2(DIGITS)   : 1;

    typedef logic [DIGITS-1:0][BCD_DIGIT_W-1:0] word_t;

    fsm_state_e                state_q, state_d;
    word_t [CHANNELS-1:0]      op_q, op_d;
    word_t                     acc_q, acc_d;
    logic                      carry_q, carry_d;
    logic                      ovf_q, ovf_d;
    logic [CH_W-1:0]           ch_q, ch_d;
    logic [DIG_W-1:0]          dig_q, dig_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    word_t                     total_q, total_d;
    logic                      max_q, max_d;
    logic                      err_q, err_d;

    logic [BCD_DIGIT_W-1:0]    add_a, add_b, add_sum;
    logic                      add_cout;
    logic                      bad_digit;

    assign add_a = op_q[ch_q][dig_q];
    assign add_b = acc_q[dig_q];

    bcd_digit_add u_add (
        .a_i    (add_a),
        .b_i    (add_b),
        .cin_i  (carry_q),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    // Any non-decimal digit in the latched operands poisons the result.
    always_comb begin
        bad_digit = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            for (int d = 0; d < DIGITS; d++) begin
                if (op_q[c][d] > BCD_NINE) bad_digit = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        ch_d    = ch_q;
        dig_d   = dig_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        total_d = total_q;
        max_d   = max_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d    = fare_in_bcd;
                    acc_d   = fare_in_bcd[DIGITS*BCD_DIGIT_W-1:0];
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                    ch_d    = CH_W'(1);
                    dig_d   = '0;
                    busy_d  = 1'b1;
                    state_d = (CHANNELS == 1) ? ST_FINISH : ST_ADD;
                end
            end

            ST_ADD: begin
                acc_d[dig_q] = add_sum;
                if (dig_q == DIG_W'(DIGITS-1)) begin
                    // A carry out of the MSD can only be reported as saturation.
                    ovf_d   = ovf_q | add_cout;
                    carry_d = 1'b0;
                    dig_d   = '0;
                    ch_d    = ch_q + 1'b1;
                    if (ch_q == CH_W'(CHANNELS-1)) state_d = ST_FINISH;
                end else begin
                    carry_d = add_cout;
                    dig_d   = dig_q + 1'b1;
                end
            end

            ST_FINISH: begin
                if (bad_digit) begin
                    total_d = '0;
                    max_d   = 1'b0;
                    err_d   = 1'b1;
                end else if (ovf_q || (acc_q >= CAP_BCD)) begin
                    total_d = CAP_BCD;
                    max_d   = 1'b1;
                    err_d   = 1'b0;
                end else begin
                    total_d = acc_q;
                    max_d   = 1'b0;
                    err_d   = 1'b0;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            ch_q    <= '0;
            dig_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            total_q <= '0;
            max_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            ch_q    <= ch_d;
            dig_q   <= dig_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            total_q <= total_d;
            max_q   <= max_d;
            err_q   <= err_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign fare_total_bcd = total_q;
    assign max            = max_q;
    assign bcd_err        = err_q;

endmodule
